// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU decode and operand issue stage; ALU_ISSUE_CNT_EN adds issue_count
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] X,
    output logic [XLEN-1:0] Y,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [31:0]     issue_count
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // Instruction fields
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};

    // Decoded (pre-register) entry
    logic            dec_legal;
    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] dec_x;
    logic [XLEN-1:0] dec_y;
    logic            dec_reg_write;

    // Pipeline register state
    logic            valid_q, valid_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            illegal_q, illegal_d;

    logic accept;
    logic handoff;

    // funct3 to ALU code for the shared OP/OP-IMM arithmetic group (funct7 = 0)
    function automatic logic [3:0] base_code(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Decode the incoming instruction into ALU code and operands
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_x     = '0;
        dec_y     = '0;
        case (opcode)
            OPC_OP: begin
                dec_x = rs1_data;
                dec_y = rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = base_code(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec_x = rs1_data;
                dec_y = imm_i;
                case (funct3)
                    3'b001: begin
                        // Shift-immediates borrow the upper immediate bits as funct7
                        dec_legal = (funct7 == F7_BASE);
                        dec_ctrl  = ALU_SLL;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SRA;
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = base_code(funct3);
                    end
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_x     = '0;
                dec_y     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_x     = pc;
                dec_y     = imm_u;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        // Illegal entries present a clean all-zero operation to the ALU
        if (!dec_legal) begin
            dec_ctrl = ALU_ADD;
            dec_x    = '0;
            dec_y    = '0;
        end
        dec_reg_write = dec_legal && (rd_field != 5'd0);
    end

    // Handshake: the slot is free when empty or being drained this cycle
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign handoff  = valid_q && out_ready;

    // Next-state for the single pipeline slot
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        x_d         = x_q;
        y_d         = y_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (handoff) begin
            valid_d = 1'b0;
        end
        // Data loads only on accept, so a held entry stays stable
        if (accept) begin
            ctrl_d      = dec_ctrl;
            x_d         = dec_x;
            y_d         = dec_y;
            rd_d        = rd_field;
            reg_write_d = dec_reg_write;
            illegal_d   = !dec_legal;
        end
    end

    // Pipeline slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= ALU_ADD;
            x_q         <= '0;
            y_q         <= '0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign alu_control = ctrl_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign rd          = rd_q;
    assign reg_write   = reg_write_q;
    assign illegal     = illegal_q;

`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count legal entries actually handed to the ALU; wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (handoff && !illegal_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Issue counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign issue_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_control;
    logic [31:0] X;
    logic [31:0] Y;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] issue_count;
`endif

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .X           (X),
        .Y           (Y),
        .rd          (rd),
        .reg_write   (reg_write),
        .illegal     (illegal)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .issue_count (issue_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: ALU mnemonics listed in alu_control order
    string names[10] = '{"ADD", "SUB", "SLL", "SLT", "SLTU", "XOR", "SRL", "SRA", "OR", "AND"};

    typedef struct {
        bit        ill;
        bit [3:0]  ctrl;
        bit [31:0] x;
        bit [31:0] y;
        bit [4:0]  rd;
        bit        rw;
    } ent_t;

    bit   m_valid = 0;
    ent_t m_ent;
    int unsigned m_cnt = 0;

    function automatic string f3name(bit [2:0] f3);
        case (f3)
            3'd0: return "ADD";
            3'd1: return "SLL";
            3'd2: return "SLT";
            3'd3: return "SLTU";
            3'd4: return "XOR";
            3'd5: return "SRL";
            3'd6: return "OR";
            default: return "AND";
        endcase
    endfunction

    function automatic string mnem(bit [31:0] i);
        bit [6:0] op = i[6:0];
        bit [2:0] f3 = i[14:12];
        bit [6:0] f7 = i[31:25];
        if (op == 7'h33) begin
            if (f7 == 7'h00) return f3name(f3);
            if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
            if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
            return "ILL";
        end
        if (op == 7'h13) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? "SLL" : "ILL";
            if (f3 == 3'd5) begin
                if (f7 == 7'h00) return "SRL";
                if (f7 == 7'h20) return "SRA";
                return "ILL";
            end
            return f3name(f3);
        end
        if (op == 7'h37) return "LUI";
        if (op == 7'h17) return "AUIPC";
        return "ILL";
    endfunction

    function automatic ent_t ref_decode(bit [31:0] i, bit [31:0] p, bit [31:0] a, bit [31:0] b);
        ent_t  e;
        string m = mnem(i);
        int    imm = int'($signed(i[31:20]));
        e.rd = i[11:7];
        e.ill = (m == "ILL");
        e.ctrl = 0; e.x = 0; e.y = 0; e.rw = 0;
        if (!e.ill) begin
            for (int k = 0; k < 10; k++) if (names[k] == m) e.ctrl = 4'(k);
            e.rw = (e.rd != 0);
            case (i[6:0])
                7'h33: begin e.x = a; e.y = b; end
                7'h13: begin e.x = a; e.y = 32'(imm); end
                7'h37: begin e.x = 0; e.y = i[31:12] << 12; end
                default: begin e.x = p; e.y = i[31:12] << 12; end
            endcase
        end
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, ".valid"}, out_valid, m_valid);
        if (m_valid) begin
            check({tag, ".ctrl"}, alu_control, m_ent.ctrl);
            check({tag, ".x"}, X, m_ent.x);
            check({tag, ".y"}, Y, m_ent.y);
            check({tag, ".rd"}, rd, m_ent.rd);
            check({tag, ".rw"}, reg_write, m_ent.rw);
            check({tag, ".ill"}, illegal, m_ent.ill);
        end
`ifdef ALU_ISSUE_CNT_EN
        check({tag, ".cnt"}, issue_count, m_cnt);
`endif
    endtask

    // One clock: drive at negedge, check ready, advance model on posedge, check outputs
    task automatic step(input string tag, input bit iv, input bit ordy, input bit fl,
                        input bit [31:0] ins, input bit [31:0] p, input bit [31:0] a, input bit [31:0] b);
        bit rdy;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; flush = fl;
        instr = ins; pc = p; rs1_data = a; rs2_data = b;
        #1;
        rdy = !m_valid || ordy;
        check({tag, ".in_ready"}, in_ready, rdy);
        @(posedge clk);
        if (m_valid && ordy && !m_ent.ill) m_cnt++;
        if (fl) m_valid = 0;
        else if (iv && rdy) begin
            m_valid = 1;
            m_ent = ref_decode(ins, p, a, b);
        end else if (ordy) m_valid = 0;
        #1;
        compare_outputs(tag);
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] w = $urandom;
        bit [6:0]  f7;
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: begin w[6:0] = 7'h33; w[31:25] = f7; end
            1: begin w[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) w[31:25] = f7; end
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    int unsigned cnt_before;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", out_valid, 0);
        check("rst.ctrl", alu_control, 0);
        check("rst.x", X, 0);
        check("rst.y", Y, 0);
        check("rst.rd", rd, 0);
        check("rst.rw", reg_write, 0);
        check("rst.ill", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD then SUB back-to-back
        step("add", 1, 1, 0, 32'h002081B3, 0, 5, 7);
        check("add.valid_k", out_valid, 1);
        check("add.ctrl_k", alu_control, 4'b0000);
        check("add.x_k", X, 5);
        check("add.y_k", Y, 7);
        check("add.rd_k", rd, 3);
        check("add.rw_k", reg_write, 1);
        step("sub", 1, 1, 0, 32'h402081B3, 0, 5, 7);
        check("sub.valid_k", out_valid, 1);
        check("sub.ctrl_k", alu_control, 4'b0001);

        // Immediates
        step("srai", 1, 1, 0, 32'h40335293, 0, 32'h80000000, 0);
        check("srai.ctrl_k", alu_control, 4'b0111);
        check("srai.y_k", Y, 32'h00000403);
        check("srai.rd_k", rd, 5);
        step("addi", 1, 1, 0, 32'hFFF00093, 0, 0, 0);
        check("addi.ctrl_k", alu_control, 4'b0000);
        check("addi.y_k", Y, 32'hFFFFFFFF);
        step("lui", 1, 1, 0, 32'h123453B7, 0, 32'hDEAD, 0);
        check("lui.x_k", X, 0);
        check("lui.y_k", Y, 32'h12345000);
        check("lui.ctrl_k", alu_control, 0);
        step("auipc", 1, 1, 0, 32'h12345397, 32'h100, 32'hDEAD, 0);
        check("auipc.x_k", X, 32'h100);
        check("auipc.y_k", Y, 32'h12345000);

        // Backpressure: hold three cycles, then accept on release, then flush a held entry
        for (int k = 0; k < 3; k++) begin
            step("bp", 1, 0, 0, 32'h002081B3, 0, 11, 22);
            check("bp.ready_k", in_ready, 0);
            check("bp.x_k", X, 32'h100);
        end
        step("bp_rel", 1, 1, 0, 32'h002081B3, 0, 11, 22);
        check("bp_rel.x_k", X, 11);
        step("hold", 0, 0, 0, 0, 0, 0, 0);
        step("flush", 1, 0, 1, 32'h002081B3, 0, 1, 2);
        check("flush.valid_k", out_valid, 0);

        // Illegal encodings
        step("ill0", 1, 1, 0, 32'h00000000, 0, 3, 4);
        check("ill0.ill_k", illegal, 1);
        check("ill0.rw_k", reg_write, 0);
        check("ill0.ctrl_k", alu_control, 0);
        step("ill1", 1, 1, 0, 32'h022081B3, 0, 3, 4);
        check("ill1.ill_k", illegal, 1);
        check("ill1.rw_k", reg_write, 0);
        check("ill1.x_k", X, 0);

`ifdef ALU_ISSUE_CNT_EN
        step("cnt_drain", 0, 1, 0, 0, 0, 0, 0);
        cnt_before = issue_count;
        step("c1", 1, 1, 0, 32'h002081B3, 0, 1, 1);
        step("c2", 1, 1, 0, 32'h002081B3, 0, 1, 1);
        step("c3", 1, 1, 0, 32'h002081B3, 0, 1, 1);
        step("c4", 1, 1, 0, 32'h00000000, 0, 1, 1);
        step("c5", 0, 1, 0, 0, 0, 0, 0);
        check("cnt.delta_k", issue_count - cnt_before, 3);
`endif

        // Async reset mid-transfer
        step("pre_rst", 1, 0, 0, 32'h002081B3, 0, 9, 9);
        #1 rst_n = 1'b0;
        #1;
        check("arst.valid", out_valid, 0);
        check("arst.ctrl", alu_control, 0);
        check("arst.x", X, 0);
        check("arst.y", Y, 0);
        m_valid = 0;
        m_cnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, rand_instr(), $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
